conv_frame_ctrl: RTL and testbench

Frame sequencer for the convolutional encoder datapath. It accepts FRAME_LEN information bits through a valid/ready handshake and feeds them to the encoder one bit per enable. It then appends K-1 zero tail bits to flush the encoder shift register, so every frame ends in state zero. It also generates the per-frame clear and completion pulses that the encoder and the downstream framing logic consume.

---
 rtl/conv_frame_ctrl.sv | 111 +++++++++++
 tb/tb_conv_frame_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the convolutional encoder: clears the encoder, streams FRAME_LEN info
// bits through a valid/ready handshake, then flushes with K-1 zero tail bits.
module conv_frame_ctrl #(
   parameter int unsigned  FRAME_LEN = 16,
   parameter int unsigned  K         = 3,
   localparam int unsigned CW_DATA   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1,
   localparam int unsigned CW        = ($clog2(K) > CW_DATA) ? $clog2(K) : CW_DATA
) (
   input  logic          clk_sig,
   input  logic          reset_sig,
   input  logic          start_sig,
   input  logic          abort_sig,
   input  logic          in_valid,
   input  logic          in_bit,
   output logic          in_ready,
   output logic          enc_clear,
   output logic          enc_en,
   output logic          enc_bit,
   output logic          tail_sig,
   output logic          busy,
   output logic          frame_done,
   output logic          aborted,
   output logic [CW-1:0] bit_idx
);

   typedef enum logic [2:0] {StIdle, StClear, StData, StTail, StDone, StAbort} state_e;

   localparam logic [CW-1:0] LastData = CW'(FRAME_LEN - 1);
   localparam logic [CW-1:0] LastTail = CW'((K > 1) ? K - 2 : 0);

   state_e        state_q, state_d;
   logic [CW-1:0] idx_q, idx_d;

   always_ff @(posedge clk_sig) begin
      if (reset_sig) begin
         state_q <= StIdle;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      in_ready   = 1'b0;
      enc_clear  = 1'b0;
      enc_en     = 1'b0;
      enc_bit    = 1'b0;
      tail_sig   = 1'b0;
      frame_done = 1'b0;
      aborted    = 1'b0;
      busy       = (state_q != StIdle);

      unique case (state_q)
         StIdle: begin
            idx_d = '0;
            if (start_sig) state_d = StClear;
         end
         StClear: begin
            enc_clear = 1'b1;
            idx_d     = '0;
            state_d   = abort_sig ? StAbort : StData;
         end
         StData: begin
            // Abort wins over a pending bit: nothing is consumed and bit_idx holds.
            in_ready = !abort_sig;
            if (abort_sig) begin
               state_d = StAbort;
            end else if (in_valid) begin
               enc_en  = 1'b1;
               enc_bit = in_bit;
               if (idx_q == LastData) begin
                  idx_d   = '0;
                  state_d = (K > 1) ? StTail : StDone;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StTail: begin
            if (abort_sig) begin
               state_d = StAbort;
            end else begin
               enc_en   = 1'b1;
               tail_sig = 1'b1;
               if (idx_q == LastTail) begin
                  idx_d   = '0;
                  state_d = StDone;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StDone: begin
            frame_done = 1'b1;
            state_d    = StIdle;
         end
         StAbort: begin
            aborted = 1'b1;
            idx_d   = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bit_idx = idx_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Scoreboard bench: two instances (FRAME_LEN=4/K=3 and FRAME_LEN=1/K=1) driven by a
// spec-timed frame driver; a negedge monitor pops expected events and checks per-cycle state.
module tb_conv_frame_ctrl;
   localparam int FL_A = 4;
   localparam int K_A  = 3;
   localparam int FL_B = 1;
   localparam int K_B  = 1;
   localparam int EV_CLEAR = 0;
   localparam int EV_EN    = 1;
   localparam int EV_DONE  = 2;
   localparam int EV_ABORT = 3;

   typedef struct {
      int dut;
      int kind;
      int b;
      int tl;
      int idx;
      int cyc;
   } ev_t;

   logic       clk_sig = 1'b0;
   logic [1:0] rst_s, start_s, abort_s, valid_s, bit_s;
   logic [1:0] ready_s, clear_s, en_s, ebit_s, tail_s, busy_s, done_s, abrt_s;
   logic [1:0] bit_idx_a;
   logic [0:0] bit_idx_b;

   ev_t exp_q[$];
   int  exp_busy[2], exp_ready[2], exp_idx[2];
   int  cyc = 0;
   int  n_cmp = 0;
   int  n_fail = 0;
   bit  mon_on = 1'b0;
   bit  hold_start = 1'b0;

   always #5 clk_sig = ~clk_sig;
   always @(posedge clk_sig) cyc <= cyc + 1;

   conv_frame_ctrl #(.FRAME_LEN(FL_A), .K(K_A)) dut_a (
      .clk_sig(clk_sig), .reset_sig(rst_s[0]), .start_sig(start_s[0]), .abort_sig(abort_s[0]),
      .in_valid(valid_s[0]), .in_bit(bit_s[0]), .in_ready(ready_s[0]), .enc_clear(clear_s[0]),
      .enc_en(en_s[0]), .enc_bit(ebit_s[0]), .tail_sig(tail_s[0]), .busy(busy_s[0]),
      .frame_done(done_s[0]), .aborted(abrt_s[0]), .bit_idx(bit_idx_a)
   );

   conv_frame_ctrl #(.FRAME_LEN(FL_B), .K(K_B)) dut_b (
      .clk_sig(clk_sig), .reset_sig(rst_s[1]), .start_sig(start_s[1]), .abort_sig(abort_s[1]),
      .in_valid(valid_s[1]), .in_bit(bit_s[1]), .in_ready(ready_s[1]), .enc_clear(clear_s[1]),
      .enc_en(en_s[1]), .enc_bit(ebit_s[1]), .tail_sig(tail_s[1]), .busy(busy_s[1]),
      .frame_done(done_s[1]), .aborted(abrt_s[1]), .bit_idx(bit_idx_b)
   );

   function automatic int fl(int d);
      return (d == 0) ? FL_A : FL_B;
   endfunction

   function automatic int tl(int d);
      return (d == 0) ? K_A - 1 : K_B - 1;
   endfunction

   function automatic logic [31:0] idx_of(int d);
      return (d == 0) ? 32'(bit_idx_a) : 32'(bit_idx_b);
   endfunction

   task automatic chk(string nm, int d, logic [31:0] act, int exp);
      n_cmp++;
      if (act !== 32'(exp)) begin
         n_fail++;
         $display("FAIL %s dut%0d cyc %0d: got %0d, expected %0d", nm, d, cyc, act, exp);
      end
   endtask

   task automatic got_event(int d, int kind, logic [31:0] b, logic [31:0] t, logic [31:0] idx);
      ev_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL event dut%0d cyc %0d: got kind %0d, expected no event", d, cyc, kind);
         return;
      end
      e = exp_q.pop_front();
      if (e.dut != d || e.kind != kind || e.cyc != cyc || b !== 32'(e.b) || t !== 32'(e.tl) ||
          (e.idx >= 0 && idx !== 32'(e.idx))) begin
         n_fail++;
         $display("FAIL event: got dut%0d kind %0d cyc %0d bit %0d tail %0d idx %0d, expected dut%0d kind %0d cyc %0d bit %0d tail %0d idx %0d",
                  d, kind, cyc, b, t, idx, e.dut, e.kind, e.cyc, e.b, e.tl, e.idx);
      end
   endtask

   always @(negedge clk_sig) begin
      if (mon_on) begin
         for (int d = 0; d < 2; d++) begin
            if (exp_busy[d] >= 0) begin
               chk("busy", d, 32'(busy_s[d]), exp_busy[d]);
               chk("in_ready", d, 32'(ready_s[d]), exp_ready[d]);
               if (exp_idx[d] >= 0) chk("bit_idx", d, idx_of(d), exp_idx[d]);
            end
            chk("clear_en_overlap", d, 32'(clear_s[d] & en_s[d]), 0);
            chk("enc_bit_gated", d, 32'(ebit_s[d] & ~en_s[d]), 0);
            chk("tail_implies_en", d, 32'(tail_s[d] & ~en_s[d]), 0);
            if (clear_s[d]) got_event(d, EV_CLEAR, 0, 0, idx_of(d));
            if (en_s[d])    got_event(d, EV_EN, 32'(ebit_s[d]), 32'(tail_s[d]), idx_of(d));
            if (done_s[d])  got_event(d, EV_DONE, 0, 0, 0);
            if (abrt_s[d])  got_event(d, EV_ABORT, 0, 0, 0);
         end
      end
   end

   task automatic step();
      @(posedge clk_sig);
      #1;
   endtask

   task automatic push(int d, int kind, int b, int t, int idx);
      ev_t e;
      e = '{dut: d, kind: kind, b: b, tl: t, idx: idx, cyc: cyc};
      exp_q.push_back(e);
   endtask

   task automatic expect_cycle(int d, int b, int r, int idx);
      exp_busy[d]  = b;
      exp_ready[d] = r;
      exp_idx[d]   = idx;
   endtask

   // Random values on inputs the controller must ignore in the current cycle.
   task automatic junk(int d);
      valid_s[d] = 1'($urandom);
      bit_s[d]   = 1'($urandom);
      abort_s[d] = 1'($urandom);
      start_s[d] = hold_start ? 1'b1 : 1'($urandom);
   endtask

   task automatic idle_cycles(int d, int n);
      repeat (n) begin
         step();
         junk(d);
         start_s[d] = 1'b0;
         expect_cycle(d, 0, 0, 0);
      end
   endtask

   task automatic abort_cycle(int d, int held);
      step();
      junk(d);
      push(d, EV_ABORT, 0, 0, -1);
      expect_cycle(d, 1, 0, held);
   endtask

   // mode: 0 normal, 1 abort in CLEAR, 2 abort at data bit 'at', 3 abort at tail bit 'at',
   // 4 synchronous reset during tail bit 'at'. Must be called with the DUT in IDLE.
   task automatic run_frame(int d, int mode, int at, int stall_max, int stall_i, int stall_n);
      int   n, t, stalls;
      logic b;
      n = fl(d);
      t = tl(d);
      step();
      junk(d);
      start_s[d] = 1'b1;
      expect_cycle(d, 0, 0, 0);
      step();
      junk(d);
      abort_s[d] = (mode == 1);
      push(d, EV_CLEAR, 0, 0, 0);
      expect_cycle(d, 1, 0, 0);
      if (mode == 1) begin
         abort_cycle(d, 0);
         return;
      end
      for (int i = 0; i < n; i++) begin
         stalls = (i == stall_i) ? stall_n : int'($urandom_range(stall_max));
         repeat (stalls) begin
            step();
            junk(d);
            valid_s[d] = 1'b0;
            abort_s[d] = 1'b0;
            expect_cycle(d, 1, 1, i);
         end
         step();
         junk(d);
         valid_s[d] = 1'b1;
         b = bit_s[d];
         if (mode == 2 && at == i) begin
            abort_s[d] = 1'b1;
            expect_cycle(d, 1, 0, i);
            abort_cycle(d, i);
            return;
         end
         abort_s[d] = 1'b0;
         push(d, EV_EN, int'(b), 0, i);
         expect_cycle(d, 1, 1, i);
      end
      for (int j = 0; j < t; j++) begin
         step();
         junk(d);
         abort_s[d] = (mode == 3 && at == j);
         if (mode == 3 && at == j) begin
            expect_cycle(d, 1, 0, j);
            abort_cycle(d, j);
            return;
         end
         push(d, EV_EN, 0, 1, j);
         expect_cycle(d, 1, 0, j);
         if (mode == 4 && at == j) begin
            rst_s[d] = 1'b1;
            step();
            rst_s[d] = 1'b0;
            junk(d);
            start_s[d] = 1'b0;
            expect_cycle(d, 0, 0, 0);
            return;
         end
      end
      step();
      junk(d);
      push(d, EV_DONE, 0, 0, -1);
      expect_cycle(d, 1, 0, -1);
   endtask

   initial begin
      int m, at;
      rst_s   = '1;
      start_s = '0;
      abort_s = '0;
      valid_s = '0;
      bit_s   = '0;
      for (int d = 0; d < 2; d++) expect_cycle(d, -1, 0, -1);
      repeat (2) step();
      rst_s = '0;
      for (int d = 0; d < 2; d++) expect_cycle(d, 0, 0, 0);
      mon_on = 1'b1;

      // FRAME_LEN=4, K=3 instance
      run_frame(0, 0, 0, 0, -1, 0);
      idle_cycles(0, 1);
      run_frame(0, 0, 0, 0, 2, 3);
      idle_cycles(0, 2);
      run_frame(0, 2, 2, 0, -1, 0);
      run_frame(0, 4, 0, 0, -1, 0);
      run_frame(0, 0, 0, 0, -1, 0);
      hold_start = 1'b1;
      repeat (3) run_frame(0, 0, 0, 0, -1, 0);
      hold_start = 1'b0;
      run_frame(0, 1, 0, 0, -1, 0);
      run_frame(0, 3, 1, 0, -1, 0);
      repeat (25) begin
         m  = int'($urandom_range(4));
         at = (m >= 3) ? int'($urandom_range(K_A - 2)) : int'($urandom_range(FL_A - 1));
         run_frame(0, m, at, 2, -1, 0);
         idle_cycles(0, int'($urandom_range(2)));
      end
      idle_cycles(0, 1);

      // FRAME_LEN=1, K=1 instance
      run_frame(1, 0, 0, 0, -1, 0);
      run_frame(1, 1, 0, 0, -1, 0);
      run_frame(1, 2, 0, 0, -1, 0);
      repeat (12) begin
         run_frame(1, int'($urandom_range(2)), 0, 2, -1, 0);
         idle_cycles(1, int'($urandom_range(2)));
      end
      hold_start = 1'b1;
      repeat (3) run_frame(1, 0, 0, 0, -1, 0);
      hold_start = 1'b0;
      idle_cycles(1, 3);

      chk("queue_drained", 0, 32'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
